// File: rtl/tag_checker.sv
// Consumer end of the DRAM-cache tag FIFO: pairs each popped entry with its
// in-order AXI R metadata read, compares tags and reports one hit/miss result.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 20
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 16
`endif

module tag_checker #(
    parameter int unsigned ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH     = `AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID   = ID_WIDTH'(`AXI_ID),
    parameter int unsigned DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int unsigned INDEX_WIDTH  = `INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = `OFFSET_WIDTH,
    parameter int unsigned TID_WIDTH    = `TID_WIDTH,
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    localparam int unsigned FIFO_WIDTH  = ADDR_WIDTH + TID_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tag_fifo_empty_i,
    input  logic [FIFO_WIDTH-1:0] tag_fifo_data_i,
    output logic                  tag_fifo_rden_o,
    input  logic [ID_WIDTH-1:0]   rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  result_hit_o,
    output logic                  result_dirty_o,
    output logic                  result_write_o,
    output logic                  result_err_o,
    output logic [TID_WIDTH-1:0]  result_tid_o,
    output logic [ADDR_WIDTH-1:0] result_addr_o,
    output logic [TAG_WIDTH-1:0]  result_victim_tag_o,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_R,
        S_DRAIN,
        S_OUT
    } state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [TID_WIDTH-1:0]  tid_q, tid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  hit_q, hit_d;
    logic                  dirty_q, dirty_d;
    logic                  err_q, err_d;
    logic [TAG_WIDTH-1:0]  victim_q, victim_d;
    logic                  valid_q, valid_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic                  rden_c;
    logic                  rready_c;

    // Per-beat decode of the metadata word
    logic                  beat_err_c;
    logic [TAG_WIDTH-1:0]  stored_tag_c;
    logic [TAG_WIDTH-1:0]  req_tag_c;
    logic                  meta_valid_c;
    logic                  meta_dirty_c;

    assign beat_err_c   = (rresp_i != 2'b00) | (rid_i != ID);
    assign stored_tag_c = rdata_i[TAG_WIDTH-1:0];
    assign meta_valid_c = rdata_i[TAG_WIDTH];
    assign meta_dirty_c = rdata_i[TAG_WIDTH+1];
    assign req_tag_c    = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

    generate
        if (DATA_WIDTH > TAG_WIDTH + 2) begin : g_rdata_upper
            logic unused_rdata_upper;
            assign unused_rdata_upper = ^rdata_i[DATA_WIDTH-1:TAG_WIDTH+2];
        end
    endgenerate

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        tid_d      = tid_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        dirty_d    = dirty_q;
        err_d      = err_q;
        victim_d   = victim_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        rden_c     = 1'b0;
        rready_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!tag_fifo_empty_i) begin
                    rden_c  = 1'b1;
                    write_d = tag_fifo_data_i[ADDR_WIDTH+TID_WIDTH];
                    tid_d   = tag_fifo_data_i[ADDR_WIDTH+TID_WIDTH-1:ADDR_WIDTH];
                    addr_d  = tag_fifo_data_i[ADDR_WIDTH-1:0];
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                rready_c = 1'b1;
                if (rvalid_i) begin
                    err_d    = beat_err_c;
                    hit_d    = meta_valid_c & (stored_tag_c == req_tag_c) & !beat_err_c;
                    dirty_d  = meta_valid_c & meta_dirty_c & !beat_err_c;
                    victim_d = stored_tag_c;
                    if (rlast_i) begin
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                rready_c = 1'b1;
                if (rvalid_i) begin
                    // A failing tail beat poisons the whole lookup
                    if (beat_err_c) begin
                        err_d = 1'b1;
                        hit_d = 1'b0;
                    end
                    if (rlast_i) begin
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (hit_q) begin
                        if (hit_cnt_q != CNT_MAX) begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else if (miss_cnt_q != CNT_MAX) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            tid_q      <= '0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            dirty_q    <= 1'b0;
            err_q      <= 1'b0;
            victim_q   <= '0;
            valid_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            tid_q      <= tid_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            dirty_q    <= dirty_d;
            err_q      <= err_d;
            victim_q   <= victim_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // The pop strobe is combinational so a FWFT entry is taken in its first IDLE cycle
    assign tag_fifo_rden_o     = rden_c & rst_n;
    assign rready_o            = rready_c;
    assign result_valid_o      = valid_q;
    assign result_hit_o        = hit_q;
    assign result_dirty_o      = dirty_q;
    assign result_write_o      = write_q;
    assign result_err_o        = err_q;
    assign result_tid_o        = tid_q;
    assign result_addr_o       = addr_q;
    assign result_victim_tag_o = victim_q;
    assign hit_cnt_o           = hit_cnt_q;
    assign miss_cnt_o          = miss_cnt_q;

endmodule
